plot_framebuffer: RTL and testbench

//  Receiving end of the pixel-plot interface that drawline drives (vga_x/vga_y/vga_colour/vga_plot).

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_ram.sv | 29 ++
 rtl/plot_framebuffer.sv | 145 ++++++++++++++
 tb/tb_plot_framebuffer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and geometry for the pixel-plot framebuffer.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef logic [2:0]  colour_t;
  typedef logic [14:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel store: synchronous write, registered read-before-write.
// Contents are deliberately not reset so it maps onto block RAM.
module fb_ram
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic     clk,
  input  logic     we,
  input  fb_addr_t waddr,
  input  colour_t  wdata,
  input  logic     re,
  input  fb_addr_t raddr,
  output colour_t  rdata
);

  colour_t mem [DEPTH];

  // Both ports use non-blocking updates, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/plot_framebuffer.sv
// Captures drawline-style pixel plots into a 160x120x3 framebuffer, with a
// one-cycle registered read-back port and a full-screen clear sequencer.
module plot_framebuffer
  import fb_pkg::*;
#(
  parameter int      WIDTH        = FB_WIDTH,
  parameter int      HEIGHT       = FB_HEIGHT,
  parameter colour_t CLEAR_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  input  logic        rd_req,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic        rd_valid,
  output logic [2:0]  rd_colour,
  output logic        rd_oob,
  output logic [15:0] wr_count,
  output logic [7:0]  oob_count
);

  localparam int       DEPTH     = WIDTH * HEIGHT;
  localparam fb_addr_t LAST_ADDR = fb_addr_t'(DEPTH - 1);
  localparam fb_addr_t ROW_PITCH = fb_addr_t'(WIDTH);
  localparam logic [8:0] X_LIM   = 9'(WIDTH);
  localparam logic [7:0] Y_LIM   = 8'(HEIGHT);

  fb_state_t state, state_nxt;
  fb_addr_t  clr_ptr;

  logic      plot_in_range, plot_ok, plot_oob;
  fb_addr_t  plot_addr;
  logic      rd_in_range;
  fb_addr_t  rd_addr;

  logic      ram_we, ram_re;
  fb_addr_t  ram_waddr, ram_raddr;
  colour_t   ram_wdata, ram_rdata;

  assign plot_in_range = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
  assign plot_addr     = fb_addr_t'(vga_y) * ROW_PITCH + fb_addr_t'(vga_x);
  // The sweep owns the write port; plots arriving meanwhile are simply lost.
  assign plot_ok       = vga_plot && plot_in_range && (state != CLEAR);
  assign plot_oob      = vga_plot && !plot_in_range && (state != CLEAR);

  assign rd_in_range = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
  assign rd_addr     = fb_addr_t'(rd_y) * ROW_PITCH + fb_addr_t'(rd_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_ptr == LAST_ADDR) state_nxt = DONE;
      DONE:    if (clr_start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr <= '0;
    end else if (state == CLEAR && clr_ptr != LAST_ADDR) begin
      clr_ptr <= clr_ptr + fb_addr_t'(1);
    end else begin
      clr_ptr <= '0;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = CLEAR_COLOUR;
    end else if (plot_ok) begin
      ram_we    = 1'b1;
      ram_waddr = plot_addr;
      ram_wdata = vga_colour;
    end
  end

  // Out-of-range reads never touch the RAM, keeping the index inside the array.
  assign ram_re    = rd_req && rd_in_range;
  assign ram_raddr = rd_in_range ? rd_addr : '0;

  fb_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_oob   <= rd_req && !rd_in_range;
    end
  end

  // Gating keeps the un-reset RAM output register invisible outside a valid read.
  assign rd_colour = (rd_valid && !rd_oob) ? ram_rdata : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count  <= '0;
      oob_count <= '0;
    end else begin
      if (plot_ok) begin
        wr_count <= wr_count + 16'd1;
      end
      if (plot_oob && oob_count != 8'hFF) begin
        oob_count <= oob_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_plot_framebuffer.sv
// Scoreboard bench for plot_framebuffer: reads push expectations from a pixel model.
module tb_plot_framebuffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic        rd_oob;
  logic [15:0] wr_count;
  logic [7:0]  oob_count;

  plot_framebuffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .rd_req     (rd_req),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_colour  (rd_colour),
    .rd_oob     (rd_oob),
    .wr_count   (wr_count),
    .oob_count  (oob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       oob;
    logic [2:0] col;
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  model [0:19199];
  int          total = 0;
  int          bad   = 0;
  int          exp_wr = 0;
  int          exp_oob = 0;
  logic        req_d = 1'b0;

  task automatic sb_pop();
    exp_t e;
    total++;
    if (rd_valid !== req_d) begin
      bad++;
      $display("FAIL rd_valid_timing: got %b want %b at %0t", rd_valid, req_d, $time);
    end
    if (rd_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: rd_valid with empty scoreboard at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (rd_colour !== e.col || rd_oob !== e.oob) begin
          bad++;
          $display("FAIL rd_data: got col=%b oob=%b want col=%b oob=%b at %0t",
                   rd_colour, rd_oob, e.col, e.oob, $time);
        end
      end
    end
  endtask

  // Advance one clock; always lands at posedge+1 with the read pipeline checked.
  task automatic step();
    @(negedge clk);
    if (rst_n) sb_pop();
    @(posedge clk);
    req_d = rd_req;
    #1;
  endtask

  task automatic plot(input int x, input int y, input logic [2:0] c);
    vga_x = 8'(x);
    vga_y = 7'(y);
    vga_colour = c;
    vga_plot = 1'b1;
    if (x < 160 && y < 120) begin
      model[y*160+x] = c;
      exp_wr++;
    end else if (exp_oob < 255) begin
      exp_oob++;
    end
    step();
    vga_plot = 1'b0;
  endtask

  task automatic push_read(input int x, input int y);
    exp_t e;
    rd_x = 8'(x);
    rd_y = 7'(y);
    rd_req = 1'b1;
    if (x < 160 && y < 120) begin
      e.oob = 1'b0;
      e.col = model[y*160+x];
    end else begin
      e.oob = 1'b1;
      e.col = 3'b000;
    end
    sb.push_back(e);
  endtask

  task automatic read(input int x, input int y);
    push_read(x, y);
    step();
    rd_req = 1'b0;
  endtask

  task automatic drain(input string name);
    step();
    step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d reads outstanding, want 0", name, sb.size());
    end
  endtask

  task automatic check_counters(input string name);
    total++;
    if (wr_count !== 16'(exp_wr) || oob_count !== 8'(exp_oob)) begin
      bad++;
      $display("FAIL %s_counters: wr=%0d oob=%0d want wr=%0d oob=%0d",
               name, wr_count, oob_count, exp_wr, exp_oob);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({clr_busy, clr_done, rd_valid, rd_colour, rd_oob, wr_count, oob_count} !== '0) begin
      bad++;
      $display("FAIL %s_zero: busy=%b done=%b vld=%b col=%b oob=%b wr=%0d oobc=%0d want all 0",
               name, clr_busy, clr_done, rd_valid, rd_colour, rd_oob, wr_count, oob_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    clr_start = 1'b0; rd_req = 1'b0; rd_x = '0; rd_y = '0;
    #12;
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_outputs_zero("post_reset");
  endtask

  task automatic test_clear();
    int n;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 20000) begin
      n++;
      step();
    end
    total++;
    if (n != 19200) begin
      bad++;
      $display("FAIL clear_len: busy cycles=%0d want 19200", n);
    end
    total++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_done: done=%b busy=%b want 1/0", clr_done, clr_busy);
    end
    for (int i = 0; i < 19200; i++) model[i] = 3'b000;
    read(0, 0);
    read(159, 119);
    drain("clear");
  endtask

  task automatic test_single_plot();
    plot(80, 90, 3'b100);
    read(80, 90);
    drain("single");
    check_counters("single");
  endtask

  task automatic test_drawline();
    int x0, y0, x1, y1, dx, dy, sx, sy, err, e2, guard;
    int px[$];
    int py[$];
    x0 = 80; y0 = 90; x1 = 60; y1 = 65;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    guard = 0;
    while (guard < 400) begin
      guard++;
      px.push_back(x0);
      py.push_back(y0);
      if (x0 == x1 && y0 == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x0 += sx; end
      if (e2 <= dx) begin err += dx; y0 += sy; end
    end
    for (int i = 0; i < px.size(); i++) plot(px[i], py[i], 3'b100);
    for (int i = 0; i < px.size(); i++) begin
      push_read(px[i], py[i]);
      step();
    end
    rd_req = 1'b0;
    read(61, 89);
    drain("drawline");
    check_counters("drawline");
  endtask

  task automatic test_oob();
    plot(160, 0, 3'b111);
    plot(0, 120, 3'b111);
    for (int i = 0; i < 300; i++) plot(200, 5, 3'b011);
    check_counters("oob");
    total++;
    if (oob_count !== 8'd255) begin
      bad++;
      $display("FAIL oob_saturate: got %0d want 255", oob_count);
    end
    read(160, 0);
    read(0, 119);
    read(159, 0);
    drain("oob");
  endtask

  task automatic test_back_to_back();
    plot(10, 10, 3'b001);
    push_read(10, 10);
    plot(10, 10, 3'b010);
    rd_req = 1'b0;
    read(10, 10);
    drain("rbw");
    check_counters("rbw");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [15:0] wr_before;
    plot(159, 119, 3'b111);
    read(159, 119);
    drain("preclear");
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 5000) begin
      n++;
      if (n == 100) begin
        wr_before = wr_count;
        plot(5, 5, 3'b110);
        plot(170, 5, 3'b110);
        model[5*160+5] = 3'b000;
        exp_wr--;
        exp_oob = 255;
        total++;
        if (wr_count !== wr_before) begin
          bad++;
          $display("FAIL plot_in_clear: wr_count %0d want %0d", wr_count, wr_before);
        end
      end else begin
        step();
      end
    end
    total++;
    if (n != 5000) begin
      bad++;
      $display("FAIL midclear_busy: busy ended after %0d cycles, want >=5000", n);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midclear_reset");
    sb.delete();
    req_d = 1'b0;
    exp_wr = 0;
    exp_oob = 0;
    for (int i = 0; i < 4000; i++) model[i] = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      bad++;
      $display("FAIL midclear_state: busy=%b done=%b want 0/0", clr_busy, clr_done);
    end
    read(0, 0);
    read(159, 119);
    drain("midclear");
    check_counters("midclear");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_single_plot();
    test_drawline();
    test_oob();
    test_back_to_back();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
